// File: rtl/bdd_pkg.sv
// -----------------------------------------------------------------------------
// bdd_pkg
// Shared definitions for the BDD accelerator node-RAM writer and traversal.
//   - FSM state constants of the tree loader
//   - frame start marker and per-record byte counts
//   - RAM2 word layout (leaf flag position, 9/9 child field split)
//   - checksum accumulation helper
// No ports (package).
// -----------------------------------------------------------------------------
package bdd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    localparam int RAM1_BYTES         = 5;
    localparam int RAM2_BYTES         = 3;

    // RAM2 word layout shared with the traversal: bit 8 flags a leaf, and
    // the 18-bit word splits into two 9-bit child fields.
    localparam int RAM2_LEAF_BIT      = 8;
    localparam int RAM2_FIELD_W       = 9;

    typedef logic [2:0] bdd_state_t;

    localparam bdd_state_t ST_IDLE    = 3'd0;
    localparam bdd_state_t ST_COUNT   = 3'd1;
    localparam bdd_state_t ST_R1      = 3'd2;
    localparam bdd_state_t ST_W1      = 3'd3;
    localparam bdd_state_t ST_R2      = 3'd4;
    localparam bdd_state_t ST_W2      = 3'd5;
    localparam bdd_state_t ST_CKSUM   = 3'd6;
    localparam bdd_state_t ST_DONE    = 3'd7;

    // Running frame checksum: XOR of every payload byte.
    function automatic logic [7:0] cksum_update(input logic [7:0] acc,
                                                input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/bdd_byte_shifter.sv
// -----------------------------------------------------------------------------
// bdd_byte_shifter
// Byte-to-word shift register. Bytes arrive MSB first; the low WIDTH bits of
// the shifted bytes are kept, so leading padding bits fall off the top.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-low reset
//   clr      in   restart the byte counter (word contents held)
//   shift    in   accept byte_in this cycle
//   byte_in  in   8-bit input byte
//   word     out  assembled word, stable until the next shift
//   full     out  high when the current shift completes the word
// -----------------------------------------------------------------------------
module bdd_byte_shifter #(
    parameter int WIDTH  = 34,
    parameter int NBYTES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word,
    output logic             full
);

    localparam int CW = $clog2(NBYTES + 1);

    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             last_byte_s;

    assign last_byte_s = (cnt_q == CW'(NBYTES - 1));

    // Next word and byte counter; counter wraps after the last byte.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (shift) begin
            word_d = {word_q[WIDTH-9:0], byte_in};
            if (last_byte_s) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (clr) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;
    assign full = shift && last_byte_s;

endmodule

// File: rtl/bdd_tree_loader.sv
// -----------------------------------------------------------------------------
// bdd_tree_loader
// Writer side of the BDD node-RAM interface. Parses a byte-serial frame
// (SYNC_BYTE, N, N x {5 RAM1 bytes, 3 RAM2 bytes}[, checksum]) and programs
// the threshold RAM (RAM1) and child-pointer RAM (RAM2).
// Build option: define BDD_LOADER_CKSUM_EN to expect and check a trailing
// XOR checksum byte over all bytes after N.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   s_data/s_valid    input byte stream;  s_ready  loader accepts byte
//   we1, we2          RAM1 / RAM2 write strobes (never together)
//   in_addr           write address for both RAMs
//   ram1_data_in      RAM1 write data;  ram2_data_in  RAM2 write data
//   load_active       frame in progress (hold off traversal)
//   done              one-cycle pulse on a completed frame
//   error             sticky; cleared by rst or the next accepted SYNC_BYTE
//   nodes_loaded      node count of the last completed frame
// All outputs are registered; they are computed from the next state.
// -----------------------------------------------------------------------------
module bdd_tree_loader
    import bdd_pkg::*;
#(
    parameter int         RAM1_DATA_WIDTH = 34,
    parameter int         RAM2_DATA_WIDTH = 18,
    parameter int         ADDR_WIDTH      = 5,
    parameter int         DEPTH           = 32,
    parameter logic [7:0] SYNC_BYTE       = bdd_pkg::SYNC_BYTE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       we1,
    output logic                       we2,
    output logic [ADDR_WIDTH-1:0]      in_addr,
    output logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
    output logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
    output logic                       load_active,
    output logic                       done,
    output logic                       error,
    output logic [ADDR_WIDTH:0]        nodes_loaded
);

    bdd_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [ADDR_WIDTH:0]   nodes_loaded_q, nodes_loaded_d;
    logic we1_q, we1_d, we2_q, we2_d, s_ready_q, s_ready_d;
    logic load_active_q, load_active_d, done_q, done_d, error_q, error_d;

    logic accept_s, sync_s, shift1_s, shift2_s, full1_s, full2_s, last_node_s;

    assign accept_s    = s_valid && s_ready_q;
    assign sync_s      = accept_s && (state_q == ST_IDLE) && (s_data == SYNC_BYTE);
    assign shift1_s    = accept_s && (state_q == ST_R1);
    assign shift2_s    = accept_s && (state_q == ST_R2);
    assign last_node_s = ({1'b0, in_addr_q} == (n_q - (ADDR_WIDTH+1)'(1)));

    bdd_byte_shifter #(.WIDTH(RAM1_DATA_WIDTH), .NBYTES(RAM1_BYTES)) u_shift1 (
        .clk(clk), .rst(rst), .clr(sync_s), .shift(shift1_s),
        .byte_in(s_data), .word(ram1_data_in), .full(full1_s)
    );

    bdd_byte_shifter #(.WIDTH(RAM2_DATA_WIDTH), .NBYTES(RAM2_BYTES)) u_shift2 (
        .clk(clk), .rst(rst), .clr(sync_s), .shift(shift2_s),
        .byte_in(s_data), .word(ram2_data_in), .full(full2_s)
    );

`ifdef BDD_LOADER_CKSUM_EN
    logic [7:0] xor_q, xor_d;

    // Checksum accumulator: restarts when N is accepted, folds in payload.
    always_comb begin
        xor_d = xor_q;
        if (shift1_s || shift2_s) begin
            xor_d = cksum_update(xor_q, s_data);
        end else if (accept_s && (state_q == ST_COUNT)) begin
            xor_d = 8'h00;
        end else begin
            xor_d = xor_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            xor_q <= 8'h00;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    // Frame FSM: next state, address, node count and error flag.
    always_comb begin
        state_d   = state_q;
        in_addr_d = in_addr_q;
        n_d       = n_q;
        error_d   = error_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_s) begin
                    error_d = 1'b0;
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (accept_s) begin
                    if ((s_data == 8'd0) || ({1'b0, s_data} > 9'(DEPTH))) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        n_d       = s_data[ADDR_WIDTH:0];
                        in_addr_d = {ADDR_WIDTH{1'b0}};
                        state_d   = ST_R1;
                    end
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_R1: begin
                if (full1_s) begin
                    state_d = ST_W1;
                end else begin
                    state_d = ST_R1;
                end
            end
            ST_W1: state_d = ST_R2;
            ST_R2: begin
                if (full2_s) begin
                    state_d = ST_W2;
                end else begin
                    state_d = ST_R2;
                end
            end
            ST_W2: begin
                if (last_node_s) begin
`ifdef BDD_LOADER_CKSUM_EN
                    state_d = ST_CKSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    in_addr_d = in_addr_q + ADDR_WIDTH'(1);
                    state_d   = ST_R1;
                end
            end
`ifdef BDD_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (accept_s) begin
                    if (s_data == xor_q) begin
                        state_d = ST_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CKSUM;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        we1_d         = (state_d == ST_W1);
        we2_d         = (state_d == ST_W2);
        done_d        = (state_d == ST_DONE);
        s_ready_d     = !((state_d == ST_W1) || (state_d == ST_W2) || (state_d == ST_DONE));
        load_active_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        if (state_d == ST_DONE) begin
            nodes_loaded_d = n_q;
        end else begin
            nodes_loaded_d = nodes_loaded_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            in_addr_q      <= {ADDR_WIDTH{1'b0}};
            n_q            <= {(ADDR_WIDTH+1){1'b0}};
            nodes_loaded_q <= {(ADDR_WIDTH+1){1'b0}};
            we1_q          <= 1'b0;
            we2_q          <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            load_active_q  <= 1'b0;
            s_ready_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            in_addr_q      <= in_addr_d;
            n_q            <= n_d;
            nodes_loaded_q <= nodes_loaded_d;
            we1_q          <= we1_d;
            we2_q          <= we2_d;
            done_q         <= done_d;
            error_q        <= error_d;
            load_active_q  <= load_active_d;
            s_ready_q      <= s_ready_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign we1          = we1_q;
    assign we2          = we2_q;
    assign in_addr      = in_addr_q;
    assign load_active  = load_active_q;
    assign done         = done_q;
    assign error        = error_q;
    assign nodes_loaded = nodes_loaded_q;

endmodule

// File: tb/tb_bdd_tree_loader.sv
// -----------------------------------------------------------------------------
// tb_bdd_tree_loader
// Self-checking bench for bdd_tree_loader. Frames are built from a list of
// node words; the expected write sequence is that list itself, and the
// checksum is recomputed from the frame bytes.
// -----------------------------------------------------------------------------
module tb_bdd_tree_loader;

    localparam int         AW    = 5;
    localparam int         DEPTH = 32;
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef struct packed {
        logic [33:0] w1;
        logic [17:0] w2;
    } node_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready, we1, we2, load_active, done, error;
    logic [AW-1:0] in_addr;
    logic [33:0]   ram1_data_in;
    logic [17:0]   ram2_data_in;
    logic [AW:0]   nodes_loaded;

    bdd_tree_loader dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .we1(we1), .we2(we2), .in_addr(in_addr), .ram1_data_in(ram1_data_in),
        .ram2_data_in(ram2_data_in), .load_active(load_active), .done(done),
        .error(error), .nodes_loaded(nodes_loaded)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    node_t      nodes[$];
    logic [7:0] frame[$];

    // Observed strobes, captured away from the active edge.
    logic [AW-1:0] q_w1a[$];
    logic [33:0]   q_w1d[$];
    logic [AW-1:0] q_w2a[$];
    logic [17:0]   q_w2d[$];
    int            n_done, n_both, la_bad, done_la_bad;
    logic [AW:0]   last_nodes;

    always @(negedge clk) begin
        if (we1) begin q_w1a.push_back(in_addr); q_w1d.push_back(ram1_data_in); end
        if (we2) begin q_w2a.push_back(in_addr); q_w2d.push_back(ram2_data_in); end
        if (we1 && we2) n_both++;
        if ((we1 || we2) && !load_active) la_bad++;
        if (done) begin
            n_done++;
            last_nodes = nodes_loaded;
            if (load_active) done_la_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q_w1a.delete(); q_w1d.delete(); q_w2a.delete(); q_w2d.delete();
        n_done = 0; n_both = 0; la_bad = 0; done_la_bad = 0;
    endtask

    task automatic gen_nodes(input int n);
        nodes.delete();
        for (int i = 0; i < n; i++) begin
            node_t nd;
            nd.w1 = {2'($urandom), 32'($urandom)};
            nd.w2 = 18'($urandom);
            nodes.push_back(nd);
        end
    endtask

    // Frame = SYNC, N, records MSB first with padding, optional checksum.
    task automatic encode(input bit rand_pad, input bit bad_ck, input int n_field);
        logic [7:0] ck, b[8], ck_byte;
        logic [5:0] p1, p2;
        frame.delete();
        frame.push_back(SYNC);
        frame.push_back(8'(n_field));
        ck = 8'h00;
        foreach (nodes[i]) begin
            p1 = rand_pad ? 6'($urandom) : 6'd0;
            p2 = rand_pad ? 6'($urandom) : 6'd0;
            b[0] = {p1, nodes[i].w1[33:32]};
            b[1] = nodes[i].w1[31:24];
            b[2] = nodes[i].w1[23:16];
            b[3] = nodes[i].w1[15:8];
            b[4] = nodes[i].w1[7:0];
            b[5] = {p2, nodes[i].w2[17:16]};
            b[6] = nodes[i].w2[15:8];
            b[7] = nodes[i].w2[7:0];
            for (int k = 0; k < 8; k++) begin
                frame.push_back(b[k]);
                ck = ck ^ b[k];
            end
        end
        ck_byte = bad_ck ? (ck ^ 8'h5A) : ck;
`ifdef BDD_LOADER_CKSUM_EN
        frame.push_back(ck_byte);
`endif
    endtask

    // Drive the frame; a byte is consumed when s_ready is high at the edge.
    task automatic send(input bit toggle);
        int i = 0;
        int cyc = 0;
        while (i < frame.size() && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (toggle && (cyc % 2 == 0)) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = frame[i];
                if (s_ready) i++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("send_budget", i, frame.size());
    endtask

    task automatic check_frame(input string tag, input bit exp_done, input bit exp_err);
        repeat (6) @(negedge clk);
        chk({tag, "_we1_cnt"}, q_w1a.size(), nodes.size());
        chk({tag, "_we2_cnt"}, q_w2a.size(), nodes.size());
        for (int i = 0; i < nodes.size() && i < q_w1a.size(); i++) begin
            chk($sformatf("%s_we1_addr%0d", tag, i), q_w1a[i], i);
            chk($sformatf("%s_we1_data%0d", tag, i), q_w1d[i], nodes[i].w1);
        end
        for (int i = 0; i < nodes.size() && i < q_w2a.size(); i++) begin
            chk($sformatf("%s_we2_addr%0d", tag, i), q_w2a[i], i);
            chk($sformatf("%s_we2_data%0d", tag, i), q_w2d[i], nodes[i].w2);
        end
        chk({tag, "_done_cnt"}, n_done, exp_done ? 1 : 0);
        if (exp_done) chk({tag, "_nodes_loaded"}, last_nodes, nodes.size());
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_strobe_overlap"}, n_both, 0);
        chk({tag, "_load_active_strobe"}, la_bad, 0);
        chk({tag, "_load_active_done"}, done_la_bad, 0);
        chk({tag, "_idle_load_active"}, load_active, 1'b0);
        chk({tag, "_idle_ready"}, s_ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_we1"}, we1, 1'b0);
        chk({tag, "_we2"}, we2, 1'b0);
        chk({tag, "_in_addr"}, in_addr, 0);
        chk({tag, "_ram1"}, ram1_data_in, 0);
        chk({tag, "_ram2"}, ram2_data_in, 0);
        chk({tag, "_load_active"}, load_active, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_nodes_loaded"}, nodes_loaded, 0);
    endtask

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        clear_mon();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Single node with known words.
        nodes.delete();
        nodes.push_back('{w1: 34'h3_0000_007F, w2: 18'h1_0203});
        encode(1'b0, 1'b0, 1);
        clear_mon(); send(1'b0); check_frame("one", 1'b1, 1'b0);

        // Three nodes, throttled stream, SYNC value inside the payload.
        gen_nodes(3);
        nodes[0].w1[7:0] = 8'hA5;
        nodes[1].w2[7:0] = 8'hA5;
        encode(1'b1, 1'b0, 3);
        clear_mon(); send(1'b1); check_frame("three_toggle", 1'b1, 1'b0);

        // Bad counts: N=0 and N=DEPTH+1, then a good frame clears error.
        nodes.delete(); encode(1'b0, 1'b0, 0);
        clear_mon(); send(1'b0); check_frame("n_zero", 1'b0, 1'b1);
        nodes.delete(); encode(1'b0, 1'b0, DEPTH + 1);
        clear_mon(); send(1'b0); check_frame("n_over", 1'b0, 1'b1);
        gen_nodes(2); encode(1'b1, 1'b0, 2);
        clear_mon(); send(1'b0); check_frame("after_err", 1'b1, 1'b0);

`ifdef BDD_LOADER_CKSUM_EN
        // Corrupted checksum: writes happen, no done, error raised.
        gen_nodes(2); encode(1'b1, 1'b1, 2);
        clear_mon(); send(1'b0); check_frame("bad_cksum", 1'b0, 1'b1);
        gen_nodes(2); encode(1'b1, 1'b0, 2);
        clear_mon(); send(1'b0); check_frame("good_cksum", 1'b1, 1'b0);
`endif

        // Reset after the 3rd byte of node 1's RAM1 record.
        gen_nodes(3); encode(1'b1, 1'b0, 3);
        while (frame.size() > 13) void'(frame.pop_back());
        clear_mon(); send(1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_reset_we1_cnt", q_w1a.size(), 1);
        chk("mid_reset_we2_cnt", q_w2a.size(), 1);
        chk("mid_reset_done_cnt", n_done, 0);
        gen_nodes(2); encode(1'b1, 1'b0, 2);
        clear_mon(); send(1'b0); check_frame("post_reset", 1'b1, 1'b0);

        // Garbage ahead of SYNC is discarded.
        gen_nodes(2); encode(1'b1, 1'b0, 2);
        frame.push_front(8'h5A); frame.push_front(8'hFF); frame.push_front(8'h00);
        clear_mon(); send(1'b0); check_frame("garbage", 1'b1, 1'b0);

        // Full-depth frame.
        gen_nodes(DEPTH); encode(1'b1, 1'b0, DEPTH);
        clear_mon(); send(1'b0); check_frame("full_depth", 1'b1, 1'b0);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            int n;
            n = $urandom_range(8, 1);
            gen_nodes(n); encode(1'b1, 1'b0, n);
            clear_mon(); send(1'($urandom)); check_frame($sformatf("rand%0d", f), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
